// File: rtl/ocr_pkg.sv
// Shared state encoding, command bytes and frame size for the OCR frame sequencer.
package ocr_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRxImg    = 3'd1,
    StStartBnn = 3'd2,
    StWaitBnn  = 3'd3,
    StResult   = 3'd4,
    StError    = 3'd5
  } seq_state_e;

  localparam logic [7:0] CMD_START = 8'hA5;
  localparam logic [7:0] CMD_ACK   = 8'hC3;
  localparam logic [7:0] CMD_CLEAR = 8'hFF;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  localparam int unsigned IMG_BYTES_DEFAULT = 113;

endpackage

// File: rtl/ocr_seq_cmd_decode.sv
// Registers the incoming SPI byte and strobe, and classifies the registered byte
// as one of the three commands or as plain data.
module ocr_seq_cmd_decode
  import ocr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       strobe_o,
  output logic [7:0] byte_o,
  output logic       is_start_o,
  output logic       is_ack_o,
  output logic       is_clear_o,
  output logic       is_data_o
);

  logic       valid_q, valid_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    valid_d = byte_valid_i;
    byte_d  = byte_valid_i ? byte_i : byte_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      byte_q  <= byte_d;
    end
  end

  assign strobe_o   = valid_q;
  assign byte_o     = byte_q;
  assign is_start_o = valid_q && (byte_q == CMD_START);
  assign is_ack_o   = valid_q && (byte_q == CMD_ACK);
  assign is_clear_o = valid_q && (byte_q == CMD_CLEAR);
  assign is_data_o  = valid_q && !is_start_o && !is_ack_o && !is_clear_o;

endmodule

// File: rtl/ocr_frame_sequencer.sv
// Top-level OCR control FSM: frame reception, BNN start, result capture and readback.
// Optional BNN watchdog enabled by defining OCR_SEQ_TIMEOUT_EN.
module ocr_frame_sequencer
  import ocr_pkg::*;
#(
  parameter int unsigned IMG_BYTES      = IMG_BYTES_DEFAULT,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_byte_valid,
  input  logic [7:0]        spi_rx_byte,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic              buf_clear,
  input  logic              buf_full,
  output logic              bnn_start,
  input  logic              bnn_result_ready,
  input  logic [3:0]        bnn_result_out,
  output logic              result_valid,
  output logic [7:0]        spi_tx_byte,
  output logic              err_overrun,
  output logic [2:0]        fsm_state
);

  localparam logic [ADDR_W-1:0] CntLast = ADDR_W'(IMG_BYTES - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [3:0]        result_q, result_d;
  logic              rdy_q, rdy_d;
  logic [3:0]        res_in_q, res_in_d;

  logic       strobe, is_start, is_ack, is_clear, is_data;
  logic [7:0] dec_byte;

  ocr_seq_cmd_decode u_cmd_decode (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (spi_byte_valid),
    .byte_i       (spi_rx_byte),
    .strobe_o     (strobe),
    .byte_o       (dec_byte),
    .is_start_o   (is_start),
    .is_ack_o     (is_ack),
    .is_clear_o   (is_clear),
    .is_data_o    (is_data)
  );

  // BNN result is registered so it lines up with the registered SPI command path.
  always_comb begin
    rdy_d    = bnn_result_ready;
    res_in_d = bnn_result_out;
  end

`ifdef OCR_SEQ_TIMEOUT_EN
  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q, wdog_d;

  // Zero everywhere outside WAIT_BNN, so the count restarts on every entry.
  always_comb begin
    wdog_d = (state_q == StWaitBnn) ? wdog_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= 4'h0;
      rdy_q    <= 1'b0;
      res_in_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      res_in_q <= res_in_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (is_start) begin
          state_d = StRxImg;
          cnt_d   = '0;
        end else if (is_clear) begin
          cnt_d = '0;
          err_d = 1'b0;
        end else if (is_data || is_ack) begin
          err_d = 1'b1;
        end
      end
      StRxImg: begin
        // Every byte is image data here; the final write wins over a late full flag.
        if (strobe && (cnt_q == CntLast)) begin
          state_d = StStartBnn;
          cnt_d   = '0;
        end else begin
          if (strobe) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
          if (buf_full) begin
            state_d = StError;
          end
        end
      end
      StStartBnn: begin
        state_d = StWaitBnn;
      end
      StWaitBnn: begin
        if (is_clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          if (strobe) begin
            err_d = 1'b1;
          end
          if (rdy_q) begin
            state_d  = StResult;
            result_d = res_in_q;
          end
`ifdef OCR_SEQ_TIMEOUT_EN
          else if (wdog_q == WdogLast) begin
            state_d = StError;
          end
`endif
        end
      end
      StResult: begin
        if (is_ack) begin
          state_d = StIdle;
        end else if (is_start) begin
          state_d = StRxImg;
          cnt_d   = '0;
        end else if (is_clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (is_data) begin
          err_d = 1'b1;
        end
      end
      StError: begin
        if (is_clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (strobe) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    buf_we       = 1'b0;
    buf_clear    = 1'b0;
    bnn_start    = 1'b0;
    result_valid = 1'b0;
    spi_tx_byte  = 8'h00;
    case (state_q)
      StIdle:     buf_clear = is_start | is_clear;
      StRxImg:    buf_we = strobe;
      StStartBnn: bnn_start = 1'b1;
      StWaitBnn:  buf_clear = is_clear;
      StResult: begin
        result_valid = 1'b1;
        spi_tx_byte  = {4'h0, result_q};
        buf_clear    = is_start | is_clear;
      end
      StError: begin
        spi_tx_byte = RESP_ERR;
        buf_clear   = is_clear;
      end
      default: ;
    endcase
  end

  assign buf_waddr   = cnt_q;
  assign buf_wdata   = dec_byte;
  assign err_overrun = err_q;
  assign fsm_state   = state_q;

endmodule
